// File: rtl/lemonde_streit_nios2_oci_dct_ctrl.sv
// OCI direct-trace capture sequencer: packs fragments, commits words to trace RAM,
// shares the RAM port with debugger readout. Optional macro NIOS2_OCI_DCT_SEQ_EN adds a word sequence number.
module lemonde_streit_nios2_oci_dct_ctrl #(
    parameter int FRAG_W = 2,
    parameter int SLOTS  = 15,
    parameter int TM_AW  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trc_on,
    input  logic                      frag_valid,
    input  logic [FRAG_W-1:0]         frag,
    input  logic                      flush_req,
    input  logic                      test_ending,
    output logic [SLOTS*FRAG_W-1:0]   dct_buffer,
    output logic [3:0]                dct_count,
    output logic                      tm_we,
    output logic [TM_AW-1:0]          tm_addr,
    output logic [35:0]               tm_wdata,
    input  logic [35:0]               tm_rdata,
    input  logic                      dbg_rd_req,
    input  logic [TM_AW-1:0]          dbg_rd_addr,
    output logic                      dbg_rd_ack,
    output logic [35:0]               dbg_rd_data,
    output logic [TM_AW-1:0]          tm_wr_ptr,
    output logic                      tm_wrapped,
    output logic                      test_has_ended
);
    localparam int BUF_W = SLOTS * FRAG_W;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN, ST_ENDED} state_t;

    state_t             state_r;
    logic [BUF_W-1:0]   dct_buffer_r;
    logic [3:0]         dct_count_r;
    logic               tm_we_r;
    logic [TM_AW-1:0]   tm_addr_r;
    logic [35:0]        tm_wdata_r;
    logic [TM_AW-1:0]   tm_wr_ptr_r;
    logic               tm_wrapped_r;
    logic               rd_grant_r;
    logic               rd_s1_r;
    logic               dbg_rd_ack_r;
    logic [35:0]        dbg_rd_data_r;
    logic               test_has_ended_r;
    logic [1:0]         word_seq_s;

    logic               accept_s;
    logic               exit_s;
    logic               commit_s;
    logic               grant_s;
    logic [BUF_W-1:0]   buf_nxt_s;
    logic [3:0]         cnt_nxt_s;

    // Fragment packing, commit decision and read-grant arbitration
    always_comb begin
        accept_s  = (state_r == ST_COLLECT) && frag_valid;
        buf_nxt_s = dct_buffer_r;
        cnt_nxt_s = dct_count_r;
        if (accept_s) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (dct_count_r == i[3:0]) begin
                    buf_nxt_s[i*FRAG_W +: FRAG_W] = frag;
                end else begin
                    buf_nxt_s[i*FRAG_W +: FRAG_W] = dct_buffer_r[i*FRAG_W +: FRAG_W];
                end
            end
            cnt_nxt_s = dct_count_r + 4'd1;
        end else begin
            cnt_nxt_s = dct_count_r;
        end
        exit_s   = flush_req || !trc_on || test_ending;
        commit_s = (state_r == ST_COLLECT) &&
                   ((cnt_nxt_s == 4'(SLOTS)) || (exit_s && (cnt_nxt_s != 4'd0)));
        // A read may only take the port in a cycle the pending register is empty
        grant_s  = dbg_rd_req && !commit_s && !rd_grant_r && !rd_s1_r && !dbg_rd_ack_r;
    end

`ifdef NIOS2_OCI_DCT_SEQ_EN
    logic [1:0] seq_r;

    // Per-word sequence number, advances on every committed word
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_r <= 2'b00;
        end else if (commit_s) begin
            seq_r <= seq_r + 2'd1;
        end else begin
            seq_r <= seq_r;
        end
    end

    assign word_seq_s = seq_r;
`else
    assign word_seq_s = 2'b00;
`endif

    // Control FSM, capture buffer, trace-RAM port and readout pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            dct_buffer_r     <= {BUF_W{1'b0}};
            dct_count_r      <= 4'd0;
            tm_we_r          <= 1'b0;
            tm_addr_r        <= {TM_AW{1'b0}};
            tm_wdata_r       <= 36'd0;
            tm_wr_ptr_r      <= {TM_AW{1'b0}};
            tm_wrapped_r     <= 1'b0;
            rd_grant_r       <= 1'b0;
            rd_s1_r          <= 1'b0;
            dbg_rd_ack_r     <= 1'b0;
            dbg_rd_data_r    <= 36'd0;
            test_has_ended_r <= 1'b0;
        end else begin
            dct_buffer_r <= commit_s ? {BUF_W{1'b0}} : buf_nxt_s;
            dct_count_r  <= commit_s ? 4'd0 : cnt_nxt_s;
            tm_we_r      <= commit_s;
            if (commit_s) begin
                tm_wdata_r  <= {word_seq_s, cnt_nxt_s, buf_nxt_s};
                tm_addr_r   <= tm_wr_ptr_r;
                tm_wr_ptr_r <= tm_wr_ptr_r + {{(TM_AW-1){1'b0}}, 1'b1};
                if (&tm_wr_ptr_r) begin
                    tm_wrapped_r <= 1'b1;
                end
            end else if (grant_s) begin
                tm_addr_r <= dbg_rd_addr;
            end
            rd_grant_r   <= grant_s;
            rd_s1_r      <= rd_grant_r;
            dbg_rd_ack_r <= rd_s1_r;
            if (rd_s1_r) begin
                dbg_rd_data_r <= tm_rdata;
            end
            case (state_r)
                ST_IDLE: begin
                    if (test_ending) begin
                        state_r <= ST_DRAIN;
                    end else if (trc_on) begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (test_ending) begin
                        state_r <= ST_DRAIN;
                    end else if (!trc_on) begin
                        state_r <= ST_IDLE;
                    end
                end
                // Any pending write retires during this cycle, so the drain is done
                ST_DRAIN: begin
                    state_r          <= ST_ENDED;
                    test_has_ended_r <= 1'b1;
                end
                ST_ENDED: begin
                    test_has_ended_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dct_buffer     = dct_buffer_r;
    assign dct_count      = dct_count_r;
    assign tm_we          = tm_we_r;
    assign tm_addr        = tm_addr_r;
    assign tm_wdata       = tm_wdata_r;
    assign dbg_rd_ack     = dbg_rd_ack_r;
    assign dbg_rd_data    = dbg_rd_data_r;
    assign tm_wr_ptr      = tm_wr_ptr_r;
    assign tm_wrapped     = tm_wrapped_r;
    assign test_has_ended = test_has_ended_r;

    lemonde_streit_nios2_oci_dct_ctrl_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit_s),
        .tm_we     (tm_we_r),
        .rd_grant  (rd_grant_r),
        .dct_count (dct_count_r)
    );
endmodule

// Invariants: pending write never lost, no read grant during a write, count in range.
module lemonde_streit_nios2_oci_dct_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic       commit,
    input logic       tm_we,
    input logic       rd_grant,
    input logic [3:0] dct_count
);
    a_pending_no_overflow: assert property (@(posedge clk) disable iff (reset) commit |=> tm_we);
    a_no_grant_on_write:   assert property (@(posedge clk) disable iff (reset) !(tm_we && rd_grant));
    a_count_range:         assert property (@(posedge clk) disable iff (reset) dct_count <= 4'd15);
endmodule
